// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the timer_ctrl channel: register map, CTRL bit layout
// and counting modes, plus the overflow next-count rule.
package timer_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_RELOAD = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_GATE    = 1;
  localparam int CTRL_CT      = 2;
  localparam int CTRL_MODE_LO = 3;
  localparam int CTRL_MODE_HI = 4;
  localparam int CTRL_IE      = 5;

  localparam int STATUS_OVF = 0;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'd0,
    MODE_RELOAD   = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_FREE_ALT = 2'd3
  } mode_e;

  // Value the counter takes on the edge where it wraps past FFFF.
  function automatic logic [15:0] overflow_value(input mode_e mode,
                                                 input logic [15:0] reload);
    logic [15:0] val;
    case (mode)
      MODE_RELOAD, MODE_ONESHOT: val = reload;
      default:                   val = 16'h0000;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/timer_ctrl_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input with a rising-edge
// detector on the synchronised level.
module tc_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // prev_q always tracks the level, so an edge seen while the channel is
  // disabled is consumed and never replayed later.
  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/timer_ctrl.sv
// One 16-bit timer/counter channel: host register file, prescaler, gated
// timer/counter ticking, reload scheduling and overflow interrupt.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int PRESCALE    = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [1:0]  addr,
  input  logic [15:0] wr_data,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        intx,
  input  logic        cin,
  output logic        irq,
  input  logic        irq_ack,
  output logic [15:0] count,
  output logic        ovf_pulse
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic          run_q, run_d;
  logic          gate_q, gate_d;
  logic          ct_q, ct_d;
  mode_e         mode_q, mode_d;
  logic          ie_q, ie_d;
  logic [15:0]   reload_q, reload_d;
  logic [15:0]   count_q, count_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ovf_flag_q, ovf_flag_d;
  logic          ovf_pulse_q;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q;

  logic intx_s;
  logic unused_intx_rise;
  logic cin_rise;
  logic cin_level_unused;

  tc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_intx (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (intx),
    .level_o (intx_s),
    .rise_o  (unused_intx_rise)
  );

  tc_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cin (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (cin),
    .level_o (cin_level_unused),
    .rise_o  (cin_rise)
  );

  logic enable;
  logic presc_wrap;
  logic tick;
  logic overflow;
  logic wr_ctrl, wr_reload, wr_count, wr_status;
  logic [15:0] ctrl_rd;

  assign enable     = run_q & (~gate_q | intx_s);
  assign presc_wrap = (presc_q == PRESC_LAST);
  assign tick       = enable & (ct_q ? cin_rise : presc_wrap);
  assign overflow   = tick & (count_q == COUNT_MAX);

  assign wr_ctrl   = wr_en & (addr == ADDR_CTRL);
  assign wr_reload = wr_en & (addr == ADDR_RELOAD);
  assign wr_count  = wr_en & (addr == ADDR_COUNT);
  assign wr_status = wr_en & (addr == ADDR_STATUS);

  always_comb begin
    ctrl_rd               = '0;
    ctrl_rd[CTRL_RUN]     = run_q;
    ctrl_rd[CTRL_GATE]    = gate_q;
    ctrl_rd[CTRL_CT]      = ct_q;
    ctrl_rd[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
    ctrl_rd[CTRL_IE]      = ie_q;
  end

  // Prescaler only advances in timer mode; any CTRL write restarts it.
  always_comb begin
    presc_d = presc_q;
    if (wr_ctrl) begin
      presc_d = '0;
    end else if (enable && !ct_q) begin
      presc_d = presc_wrap ? '0 : presc_q + 1'b1;
    end
  end

  // Later assignments take priority: host writes beat tick/reload effects.
  always_comb begin
    count_d = count_q;
    if (tick) begin
      count_d = overflow ? overflow_value(mode_q, reload_q) : count_q + 16'd1;
    end
    if (wr_count) begin
      count_d = wr_data;
    end
  end

  always_comb begin
    run_d  = run_q;
    gate_d = gate_q;
    ct_d   = ct_q;
    mode_d = mode_q;
    ie_d   = ie_q;
    if (overflow && mode_q == MODE_ONESHOT) begin
      run_d = 1'b0;
    end
    if (wr_ctrl) begin
      run_d  = wr_data[CTRL_RUN];
      gate_d = wr_data[CTRL_GATE];
      ct_d   = wr_data[CTRL_CT];
      mode_d = mode_e'(wr_data[CTRL_MODE_HI:CTRL_MODE_LO]);
      ie_d   = wr_data[CTRL_IE];
    end
  end

  assign reload_d = wr_reload ? wr_data : reload_q;

  // irq is a level request; the host answers with a one-cycle irq_ack (or a
  // STATUS write of bit 0) to drop it, and an overflow on that same edge keeps it.
  always_comb begin
    ovf_flag_d = ovf_flag_q;
    if (overflow) begin
      ovf_flag_d = 1'b1;
    end else if (irq_ack || (wr_status && wr_data[STATUS_OVF])) begin
      ovf_flag_d = 1'b0;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      case (addr)
        ADDR_CTRL:   rd_data_d = ctrl_rd;
        ADDR_RELOAD: rd_data_d = reload_q;
        ADDR_COUNT:  rd_data_d = count_q;
        default:     rd_data_d = {15'b0, ovf_flag_q};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q       <= 1'b0;
      gate_q      <= 1'b0;
      ct_q        <= 1'b0;
      mode_q      <= MODE_FREE;
      ie_q        <= 1'b0;
      reload_q    <= '0;
      count_q     <= '0;
      presc_q     <= '0;
      ovf_flag_q  <= 1'b0;
      ovf_pulse_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      run_q       <= run_d;
      gate_q      <= gate_d;
      ct_q        <= ct_d;
      mode_q      <= mode_d;
      ie_q        <= ie_d;
      reload_q    <= reload_d;
      count_q     <= count_d;
      presc_q     <= presc_d;
      ovf_flag_q  <= ovf_flag_d;
      ovf_pulse_q <= overflow;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_en;
    end
  end

  assign irq       = ovf_flag_q & ie_q;
  assign count     = count_q;
  assign ovf_pulse = ovf_pulse_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: register reads go through an expected-value
// queue, all other observations are checked in place against hand-derived values.
module tb_timer_ctrl;

  localparam int P = 4;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en, rd_en;
  logic [1:0]  addr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        intx, cin;
  logic        irq, irq_ack;
  logic [15:0] count;
  logic        ovf_pulse;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  timer_ctrl #(.PRESCALE(P), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .intx      (intx),
    .cin       (cin),
    .irq       (irq),
    .irq_ack   (irq_ack),
    .count     (count),
    .ovf_pulse (ovf_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] want;
    exp_q.push_back(exp);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 4 && rd_valid !== 1'b1; i++) tick();
    check({tag, "_valid"}, {15'b0, rd_valid}, 16'h0001);
    want = exp_q.pop_front();
    if (rd_valid === 1'b1) check(tag, rd_data, want);
  endtask

  initial begin
    logic [15:0] rl_new;

    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = 2'd0; wr_data = '0;
    intx = 1'b0; cin = 1'b0; irq_ack = 1'b0;
    ticks(3);
    check("rst_count", count, 16'h0000);
    check("rst_irq", {15'b0, irq}, 16'h0);
    check("rst_rd_valid", {15'b0, rd_valid}, 16'h0);
    check("rst_rd_data", rd_data, 16'h0000);
    check("rst_ovf_pulse", {15'b0, ovf_pulse}, 16'h0);
    reset_n = 1'b1;
    tick();
    rd(2'd0, 16'h0000, "rst_ctrl");
    rd(2'd1, 16'h0000, "rst_reload");
    rd(2'd3, 16'h0000, "rst_status");

    // Free-running timer across the FFFF wrap
    wr(2'd2, 16'hFFFE);
    wr(2'd0, 16'h0001);
    ticks(P - 1);
    check("free_pre_tick", count, 16'hFFFE);
    tick();
    check("free_tick1", count, 16'hFFFF);
    ticks(P - 1);
    check("free_pre_wrap", count, 16'hFFFF);
    check("free_no_pulse", {15'b0, ovf_pulse}, 16'h0);
    tick();
    check("free_wrap", count, 16'h0000);
    check("free_pulse", {15'b0, ovf_pulse}, 16'h1);
    rd(2'd3, 16'h0001, "free_status");
    check("free_pulse_gone", {15'b0, ovf_pulse}, 16'h0);
    check("free_irq_off", {15'b0, irq}, 16'h0);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    rd(2'd3, 16'h0000, "status_cleared");

    // Auto-reload with interrupt and acknowledge
    wr(2'd1, 16'hFF00);
    wr(2'd0, 16'h0029);
    wr(2'd2, 16'hFFFF);
    ticks(P - 2);
    check("reload_pre", count, 16'hFFFF);
    check("reload_irq_pre", {15'b0, irq}, 16'h0);
    tick();
    check("reload_count", count, 16'hFF00);
    check("reload_irq", {15'b0, irq}, 16'h1);
    check("reload_pulse", {15'b0, ovf_pulse}, 16'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("ack_clears", {15'b0, irq}, 16'h0);
    wr(2'd0, 16'h0029);
    wr(2'd2, 16'hFFFF);
    ticks(P - 2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("ack_vs_ovf_irq", {15'b0, irq}, 16'h1);
    check("ack_vs_ovf_count", count, 16'hFF00);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);

    // One-shot: reload then stop
    wr(2'd1, 16'h1234);
    wr(2'd0, 16'h0011);
    wr(2'd2, 16'hFFFF);
    ticks(P - 2);
    tick();
    check("oneshot_count", count, 16'h1234);
    check("oneshot_pulse", {15'b0, ovf_pulse}, 16'h1);
    rd(2'd0, 16'h0010, "oneshot_ctrl");
    ticks(3 * P);
    check("oneshot_hold", count, 16'h1234);
    check("oneshot_irq_off", {15'b0, irq}, 16'h0);

    // RELOAD write on the overflow edge: old value loads, new value stored
    rl_new = 16'($urandom_range(16'h0100, 16'hFEFF));
    wr(2'd0, 16'h0009);
    wr(2'd2, 16'hFFFF);
    ticks(P - 2);
    wr(2'd1, rl_new);
    check("reload_coll_count", count, 16'h1234);
    rd(2'd1, rl_new, "reload_coll_stored");
    wr(2'd0, 16'h0000);

    // Gated counter mode
    wr(2'd2, 16'h0000);
    wr(2'd0, 16'h0007);
    for (int k = 0; k < 5; k++) begin
      cin = 1'b1; ticks(2); cin = 1'b0; ticks(2);
    end
    ticks(S + 2);
    check("gated_hold", count, 16'h0000);
    intx = 1'b1;
    ticks(S + 2);
    for (int k = 0; k < 5; k++) begin
      cin = 1'b1;
      ticks(S);
      check("cin_latency_pre", count, 16'(k));
      tick();
      check("cin_latency_post", count, 16'(k + 1));
      cin = 1'b0;
      ticks(2);
    end
    check("cin_total", count, 16'h0005);

    // COUNT write on a tick edge, then STATUS clear on an overflow edge
    wr(2'd0, 16'h0001);
    ticks(P - 1);
    wr(2'd2, 16'h0010);
    check("count_wr_vs_tick", count, 16'h0010);
    ticks(P - 1);
    tick();
    check("count_after_wr", count, 16'h0011);
    wr(2'd0, 16'h0000);
    wr(2'd3, 16'h0001);
    rd(2'd3, 16'h0000, "status_pre_coll");
    wr(2'd0, 16'h0001);
    wr(2'd2, 16'hFFFF);
    ticks(P - 2);
    wr(2'd3, 16'h0001);
    check("status_coll_pulse", {15'b0, ovf_pulse}, 16'h1);
    check("status_coll_count", count, 16'h0000);
    rd(2'd3, 16'h0001, "status_coll_flag");

    // Reset in the middle of a prescaler period
    wr(2'd0, 16'h0000);
    wr(2'd2, 16'h0123);
    wr(2'd0, 16'h0021);
    check("pre_reset_irq", {15'b0, irq}, 16'h1);
    rd(2'd2, 16'h0123, "pre_reset_count");
    tick();
    reset_n = 1'b0;
    #2;
    check("mid_reset_count", count, 16'h0000);
    check("mid_reset_irq", {15'b0, irq}, 16'h0);
    check("mid_reset_rd_data", rd_data, 16'h0000);
    check("mid_reset_rd_valid", {15'b0, rd_valid}, 16'h0);
    ticks(2);
    reset_n = 1'b1;
    ticks(3);
    check("post_reset_count", count, 16'h0000);
    check("post_reset_pulse", {15'b0, ovf_pulse}, 16'h0);
    rd(2'd0, 16'h0000, "post_reset_ctrl");
    rd(2'd1, 16'h0000, "post_reset_reload");
    rd(2'd3, 16'h0000, "post_reset_status");
    wr(2'd0, 16'h0001);
    ticks(P - 1);
    check("restart_pre_tick", count, 16'h0000);
    tick();
    check("restart_first_tick", count, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Controller and sequencer for one 16-bit timer/counter channel, with a simple register interface for host configuration. Owns the run/gate/mode configuration, prescaler, input synchronisation, reload scheduling, overflow flag and interrupt request/acknowledge handshake. Sits between the host bus and interrupt controller, one instance per timer channel.

Parameters:
PRESCALE, 12, internal clocks per timer-mode tick (>=2)
SYNC_STAGES, 2, flip-flop stages on asynchronous inputs intx and cin (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
wr_en  in  1  register write strobe, one cycle
rd_en  in  1  register read strobe, one cycle
addr  in  2  0=CTRL, 1=RELOAD, 2=COUNT, 3=STATUS
wr_data  in  16  write data
rd_data  out  16  read data, registered
rd_valid  out  1  pulses one cycle after rd_en
intx  in  1  external gate input (async)
cin  in  1  external count input (async)
irq  out  1  interrupt request, level
irq_ack  in  1  interrupt acknowledge, one-cycle pulse
count  out  16  current count value
ovf_pulse  out  1  one-cycle pulse on each overflow

Behaviour:
- Reset: CTRL=0, RELOAD=0, count=0, prescaler=0, ovf flag=0, sync chains=0; rd_data=0, rd_valid=0, irq=0, ovf_pulse=0.
- CTRL bits: [0] run, [1] gate, [2] c_t (0=timer, 1=counter), [4:3] mode, [5] ie; other bits read 0.
- enable = run & (~gate | intx_s), where intx_s is the synchronised intx.
- Timer mode: while enable=1, prescaler increments each cycle; at PRESCALE-1 it wraps to 0 and issues a tick. While enable=0, prescaler holds.
- Counter mode: tick on rising edge of synchronised cin while enable=1. Latency from cin pin to count change is SYNC_STAGES+1 cycles. An edge while disabled is dropped.
- Any CTRL write clears the prescaler to 0.
- Tick with count != FFFF: count+1.
- Tick with count == FFFF (overflow): ovf_pulse=1 for that cycle and ovf flag set. Count next value depends on mode:
  - Mode 0: 0000.
  - Mode 1: RELOAD.
  - Mode 2 (one-shot): RELOAD, and CTRL.run is cleared in the same edge.
  - Mode 3: behaves as mode 0.
- irq = ovf_flag & ie, combinationally from registered state.
- ovf flag clears on irq_ack or on a STATUS write with wr_data[0]=1. If an overflow coincides with a clear, the set wins.
- Writes:
  - COUNT write overrides a same-cycle tick or reload.
  - RELOAD write same cycle as an overflow: the old RELOAD value is loaded, and the new value is stored.
  - CTRL write same cycle as a mode-2 overflow: the written run bit wins.
- Reads: rd_data/rd_valid valid one cycle after rd_en. STATUS reads {15'b0, ovf_flag}; COUNT reads the pre-edge value. Simultaneous rd_en and wr_en to the same address returns the old value.
- reset_n low mid-operation: all state returns to reset values immediately; no pulse is generated on release.

Decomposition:
- Package timer_ctrl_pkg: address constants (ADDR_CTRL=0, ADDR_RELOAD=1, ADDR_COUNT=2, ADDR_STATUS=3), CTRL bit-index constants, mode encodings (MODE_FREE=0, MODE_RELOAD=1, MODE_ONESHOT=2).
- Sub-module tc_sync_edge: SYNC_STAGES flop synchroniser plus rising-edge detector. Instantiated for cin; intx uses its level output only.

Test Plan:
- Timer, free-run: PRESCALE=4, CTRL=0x01, COUNT=FFFE -> count=FFFF after 4 clk, 0000 after 8 clk. ovf_pulse on the wrap edge; STATUS reads 1; irq stays 0 (ie=0).
- Auto-reload with interrupt: RELOAD=0xFF00, COUNT=FFFF, CTRL=0x29 (run, ie, mode1) -> next tick count=FF00 and irq=1. irq_ack pulse -> irq=0 next cycle. Ack coinciding with a second overflow -> irq stays 1.
- One-shot: CTRL=0x11, RELOAD=0x1234, COUNT=FFFF -> after overflow count=1234, CTRL.run=0, and count holds for 3*PRESCALE cycles.
- Gated counter: CTRL=0x07 (run, gate, counter), 5 cin pulses with intx=0 -> count unchanged. Raise intx, then 5 cin pulses -> count=5, each increment SYNC_STAGES+1 cycles after its cin edge.
- Collisions: COUNT write 0x0010 on the same cycle as a tick -> count=0x0010. STATUS write 0x0001 on the same cycle as an overflow -> flag remains 1.
- Reset mid-count: reset_n low at count=0x0123 with prescaler mid-cycle -> count=0, irq=0, rd_data=0; after release the first tick occurs PRESCALE cycles after run is set again.
